// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : load_store_unit                                             |
// | Description: MEM-stage initiator for a word-organised data memory.       |
// |              Turns byte-addressed loads/stores into word accesses,       |
// |              extends sub-word loads and merges sub-word stores by a      |
// |              read-modify-write. One response pulse per request.          |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module load_store_unit #(
   parameter int N     = 32,
   parameter int DEPTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [1:0]   req_size,
   input  logic         req_signed,
   input  logic [N-1:0] req_addr,
   input  logic [N-1:0] req_wdata,
   output logic         rsp_valid,
   output logic [N-1:0] rsp_rdata,
   output logic         rsp_err,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata,
   output logic         mem_read,
   output logic         mem_we
);

   localparam logic [1:0]   SZ_BYTE     = 2'b00;
   localparam logic [1:0]   SZ_HALF     = 2'b01;
   localparam logic [1:0]   SZ_WORD     = 2'b10;
   localparam logic [1:0]   SZ_ILLEGAL  = 2'b11;
   localparam logic [N-1:0] DEPTH_LIMIT = N'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_STORE  = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4
   } state_t;

   state_t         state_q,     state_d;
   logic [1:0]     addr_lo_q,   addr_lo_d;
   logic [1:0]     size_q,      size_d;
   logic           signed_q,    signed_d;
   logic [15:0]    wdata_lo_q,  wdata_lo_d;   // only byte/half stores reuse it
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_err_q,   rsp_err_d;
   logic [N-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [N-1:0]   mem_addr_q,  mem_addr_d;
   logic [N-1:0]   mem_wdata_q, mem_wdata_d;

   logic           w_accept;
   logic           w_bad_align;
   logic           w_out_of_range;
   logic [N-1:0]   w_index;
   logic [7:0]     w_lane_byte;
   logic [15:0]    w_lane_half;
   logic [N-1:0]   w_load_data;
   logic [N-1:0]   w_merged;

   // Strobes and ready are pure state decodes so an async reset drops them at once
   assign req_ready = (state_q == S_IDLE);
   assign mem_read  = (state_q == S_LOAD)  || (state_q == S_RMW_RD);
   assign mem_we    = (state_q == S_STORE) || (state_q == S_RMW_WR);
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   assign w_accept       = req_valid && (state_q == S_IDLE);
   assign w_index        = {2'b00, req_addr[N-1:2]};
   assign w_bad_align    = (req_size == SZ_ILLEGAL)
                        || ((req_size == SZ_HALF) && req_addr[0])
                        || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
   assign w_out_of_range = (w_index >= DEPTH_LIMIT);

   // Extract the addressed lane of the read word and extend it to full width
   always_comb begin
      w_lane_byte = mem_rdata[{addr_lo_q, 3'b000} +: 8];
      w_lane_half = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
      w_load_data = mem_rdata;
      case (size_q)
         SZ_BYTE: w_load_data = {{(N-8){signed_q & w_lane_byte[7]}}, w_lane_byte};
         SZ_HALF: w_load_data = {{(N-16){signed_q & w_lane_half[15]}}, w_lane_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   // Replace the addressed lane of the read word with the store data
   always_comb begin
      w_merged = mem_rdata;
      case (size_q)
         SZ_BYTE: w_merged[{addr_lo_q, 3'b000} +: 8]     = wdata_lo_q[7:0];
         SZ_HALF: w_merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_lo_q;
         default: w_merged = mem_rdata;
      endcase
   end

   // Next-state and next-output computation for the access sequencer
   always_comb begin
      state_d     = state_q;
      addr_lo_d   = addr_lo_q;
      size_d      = size_q;
      signed_d    = signed_q;
      wdata_lo_d  = wdata_lo_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               addr_lo_d  = req_addr[1:0];
               size_d     = req_size;
               signed_d   = req_signed;
               wdata_lo_d = req_wdata[15:0];
               mem_addr_d = w_index;
               if (w_bad_align || w_out_of_range) begin
                  // Error is answered straight from IDLE; the memory is never touched
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else if (!req_write) begin
                  state_d = S_LOAD;
               end else if (req_size == SZ_WORD) begin
                  mem_wdata_d = req_wdata;
                  state_d     = S_STORE;
               end else begin
                  state_d = S_RMW_RD;
               end
            end
         end
         S_LOAD: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = w_load_data;
            state_d     = S_IDLE;
         end
         S_STORE: begin
            rsp_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         S_RMW_RD: begin
            // Merging at capture time keeps mem_wdata steady through the write cycle
            mem_wdata_d = w_merged;
            state_d     = S_RMW_WR;
         end
         S_RMW_WR: begin
            rsp_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_lo_q   <= '0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         wdata_lo_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_lo_q   <= addr_lo_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         wdata_lo_q  <= wdata_lo_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_load_store_unit                                          |
// | Description: Scoreboard bench for load_store_unit with an attached word  |
// |              memory, directed cases and randomized traffic.              |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;
   localparam int N     = 32;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [N-1:0]  req_addr;
   logic [N-1:0]  req_wdata;
   logic          rsp_valid;
   logic [N-1:0]  rsp_rdata;
   logic          rsp_err;
   logic [N-1:0]  mem_addr;
   logic [N-1:0]  mem_wdata;
   logic [N-1:0]  mem_rdata;
   logic          mem_read;
   logic          mem_we;

   load_store_unit #(.N(N), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_read   (mem_read),
      .mem_we     (mem_we)
   );

   always #5 clk = ~clk;

   // Attached data memory: combinational read, write on the falling edge
   logic [31:0] mem [0:DEPTH-1];
   bit          mem_init_done = 1'b0;
   assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[4:0]] : 32'h0;
   always @(negedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i);
         mem_init_done <= 1'b1;
      end else if (mem_we && (mem_addr < DEPTH)) begin
         mem[mem_addr[4:0]] <= mem_wdata;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] ref_mem [0:DEPTH-1];
   int          checks = 0;
   int          passes = 0;
   int          strobe_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
   endtask

   // Reference model: architectural effect of one request on a word array
   function automatic exp_t model(input bit wr, input bit [1:0] sz, input bit sgn,
                                  input logic [31:0] addr, input logic [31:0] wd, input int a);
      exp_t        e;
      logic [31:0] idx, off, w, v, mask;
      idx = addr / 4;
      off = addr % 4;
      e.rdata = 32'h0;
      e.err   = 1'b0;
      if ((sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0) || (sz == 2'd2 && off != 0)
          || (idx >= DEPTH)) begin
         e.err = 1'b1;
         e.due = a;
         return e;
      end
      w = ref_mem[idx];
      if (!wr) begin
         e.due = a + 1;
         if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (sgn && v >= 32'h80) v = v - 32'h100;
         end else if (sz == 2'd1) begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v - 32'h10000;
         end else begin
            v = w;
         end
         e.rdata = v;
      end else if (sz == 2'd2) begin
         ref_mem[idx] = wd;
         e.due = a + 1;
      end else begin
         mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
         ref_mem[idx] = (w & ~mask) | ((wd << (8 * off)) & mask);
         e.due = a + 2;
      end
      return e;
   endfunction

   // Monitor: pops the scoreboard on every response and checks bus rules
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_read || mem_we) begin
            strobe_cnt++;
            chk("strobe_exclusive", 32'(mem_read & mem_we), 32'h0);
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, mon_e.rdata);
               chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
               chk("rsp_latency", 32'(cyc), 32'(mon_e.due));
            end
         end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
            chk("rsp_missing", 32'(rsp_valid), 32'h1);
            void'(exp_q.pop_front());
         end
      end
   end

   // Present one request, wait for acceptance, push its expected response
   task automatic issue(input bit wr, input bit [1:0] sz, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
      int g;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
      g = 0;
      while (!req_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", 32'(req_ready), 32'h1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      exp_q.push_back(model(wr, sz, sgn, addr, wd, cyc));
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 20) begin
         @(negedge clk);
         #1;
         g++;
      end
      chk("drain", 32'(exp_q.size()), 32'h0);
   endtask

   int          s0;
   logic [31:0] saved;

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'h1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rsp_err", 32'(rsp_err), 32'h0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk("reset_mem_read", 32'(mem_read), 32'h0);
      chk("reset_mem_we", 32'(mem_we), 32'h0);
      chk("reset_mem_addr", mem_addr, 32'h0);
      chk("reset_mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;

      // LW 0x14: word 5 presented during the read cycle
      issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
      chk("lw_mem_read", 32'(mem_read), 32'h1);
      chk("lw_mem_addr", mem_addr, 32'h5);
      drain();

      // SB 0x80 @0x09, then signed/unsigned byte loads
      issue(1'b1, 2'd0, 1'b0, 32'h09, 32'h80);
      issue(1'b0, 2'd0, 1'b1, 32'h09, 32'h0);
      issue(1'b0, 2'd0, 1'b0, 32'h09, 32'h0);
      drain();
      chk("sb_mem2", mem[2], 32'h00008002);

      // SH 0xBEEF @0x0E, then signed/unsigned half loads
      issue(1'b1, 2'd1, 1'b0, 32'h0E, 32'hBEEF);
      issue(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
      issue(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0);
      drain();
      chk("sh_mem3", mem[3], 32'hBEEF0003);

      // Error cases never strobe the memory
      s0 = strobe_cnt;
      issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
      issue(1'b1, 2'd1, 1'b0, 32'h03, 32'h1234);
      issue(1'b0, 2'd3, 1'b0, 32'h00, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
      drain();
      chk("err_no_strobe", 32'(strobe_cnt - s0), 32'h0);
      chk("err_mem0", mem[0], 32'h0);

      // Reset mid-load: outputs return to idle without a clock edge
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'h1);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_mem_we", 32'(mem_we), 32'h0);
      chk("midrst_mem_read", 32'(mem_read), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset during RMW read: the store must not land
      saved = ref_mem[1];
      issue(1'b1, 2'd0, 1'b0, 32'h04, 32'hAA);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      ref_mem[1] = saved;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rmwrst_mem1", mem[1], 32'h1);
      issue(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
      drain();

      // Randomized traffic with occasional idle gaps
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         bit [1:0]    sz;
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
         a  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 143));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, 32'($urandom));
      end
      drain();
      for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
